ts_cc_monitor: RTL and testbench

TS_CC_MONITOR -- requirements
Module: ts_cc_monitor

---
 rtl/ts_cc_monitor_pkg.sv | 39 +++
 rtl/ts_pid_table.sv | 86 ++++++++
 rtl/ts_cc_monitor.sv | 194 +++++++++++++++++++
 tb/tb_ts_cc_monitor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_cc_monitor_pkg.sv
// Shared constants, FSM encoding and table entry layout for the TS continuity monitor.
package ts_cc_monitor_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'h47;
    localparam logic [7:0]  PKT_LEN   = 8'd188;
    localparam logic [7:0]  PKT_LAST  = PKT_LEN - 8'd1;
    localparam logic [12:0] NULL_PID  = 13'h1FFF;

    localparam logic [1:0] AFC_RESERVED      = 2'b00;
    localparam logic [1:0] AFC_PAYLOAD       = 2'b01;
    localparam logic [1:0] AFC_ADAPT         = 2'b10;
    localparam logic [1:0] AFC_ADAPT_PAYLOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_H1   = 3'd1,
        ST_H2   = 3'd2,
        ST_H3   = 3'd3,
        ST_BODY = 3'd4
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [12:0] pid;
        logic [3:0]  cc;
        logic        dup;
    } pid_entry_t;

    function automatic logic has_payload(input logic [1:0] afc);
        logic r;
        case (afc)
            AFC_PAYLOAD, AFC_ADAPT_PAYLOAD: r = 1'b1;
            AFC_RESERVED, AFC_ADAPT:        r = 1'b0;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ts_pid_table.sv
// Per-PID continuity-counter table: combinational lookup/check, registered update.
module ts_pid_table
    import ts_cc_monitor_pkg::*;
#(
    parameter int TABLE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        check_en,
    input  logic [12:0] pid,
    input  logic [3:0]  cc,
    input  logic [1:0]  afc,
    output logic        cc_mismatch,
    output logic        full
);

    localparam int IW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;

    pid_entry_t             table_r [TABLE_DEPTH];
    pid_entry_t             stored_s;
    logic                   hit_s;
    logic                   free_s;
    logic [IW-1:0]          hit_idx_s;
    logic [IW-1:0]          free_idx_s;
    logic [TABLE_DEPTH-1:0] valid_vec_s;
    logic [3:0]             cc_inc_s;
    logic                   mismatch_s;
    logic                   dup_next_s;

    // Lowest-index matching entry and lowest-index free entry.
    always_comb begin
        hit_s       = 1'b0;
        free_s      = 1'b0;
        hit_idx_s   = '0;
        free_idx_s  = '0;
        valid_vec_s = '0;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            valid_vec_s[i] = table_r[i].valid;
            hit_idx_s  = (table_r[i].valid && table_r[i].pid == pid && !hit_s) ? IW'(i) : hit_idx_s;
            hit_s      = hit_s | (table_r[i].valid && table_r[i].pid == pid);
            free_idx_s = (!table_r[i].valid && !free_s) ? IW'(i) : free_idx_s;
            free_s     = free_s | !table_r[i].valid;
        end
    end

    assign stored_s = table_r[hit_idx_s];
    assign cc_inc_s = stored_s.cc + 4'd1;

    // Continuity rule: one repeat of the last CC is tolerated when payload is present.
    always_comb begin
        mismatch_s = 1'b0;
        dup_next_s = 1'b0;
        if (has_payload(afc)) begin
            if (cc == cc_inc_s) begin
                mismatch_s = 1'b0;
                dup_next_s = 1'b0;
            end else if (cc == stored_s.cc) begin
                mismatch_s = stored_s.dup;
                dup_next_s = 1'b1;
            end else begin
                mismatch_s = 1'b1;
                dup_next_s = 1'b0;
            end
        end else begin
            mismatch_s = (cc != stored_s.cc);
            dup_next_s = 1'b0;
        end
    end

    assign cc_mismatch = check_en && hit_s && mismatch_s;
    assign full        = &valid_vec_s;

    // Table update: refresh on hit, allocate on miss while space remains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                table_r[i] <= '0;
            end
        end else if (check_en && hit_s) begin
            table_r[hit_idx_s] <= '{valid: 1'b1, pid: pid, cc: cc, dup: dup_next_s};
        end else if (check_en && free_s) begin
            table_r[free_idx_s] <= '{valid: 1'b1, pid: pid, cc: cc, dup: 1'b0};
        end
    end

endmodule

// File: rtl/ts_cc_monitor.sv
// MPEG-TS packet framer with per-PID continuity-counter checking.
module ts_cc_monitor
    import ts_cc_monitor_pkg::*;
#(
    parameter int TABLE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        sync_locked,
    output logic [7:0]  byte_out,
    output logic        byte_out_valid,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic [12:0] pid,
    output logic        hdr_valid,
    output logic        tei_err,
    output logic        cc_err,
    output logic        sync_loss,
    output logic        table_full,
    output logic [15:0] cc_err_count,
    output logic [31:0] pkt_count
);

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  idx_r;
    logic [7:0]  idx_next_s;
    logic        tei_cap_r;
    logic [4:0]  pid_hi_r;
    logic [7:0]  pid_lo_r;
    logic        in_frame_s;
    logic        sop_s;
    logic        eop_s;
    logic        hdr_accept_s;
    logic        loss_s;
    logic [12:0] hdr_pid_s;
    logic        check_en_s;
    logic        mismatch_s;
    logic        full_s;

    assign hdr_pid_s  = {pid_hi_r, pid_lo_r};
    assign check_en_s = hdr_accept_s && !tei_cap_r && (hdr_pid_s != NULL_PID);

    // Framing next-state; idx_r is the index the next accepted byte will carry.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        in_frame_s   = 1'b0;
        sop_s        = 1'b0;
        eop_s        = 1'b0;
        hdr_accept_s = 1'b0;
        loss_s       = 1'b0;
        if (!sync_locked) begin
            state_next_s = ST_HUNT;
            idx_next_s   = 8'd0;
        end else if (byte_valid) begin
            case (state_r)
                ST_HUNT: begin
                    if (byte_in == SYNC_BYTE) begin
                        state_next_s = ST_H1;
                        idx_next_s   = 8'd1;
                        in_frame_s   = 1'b1;
                        sop_s        = 1'b1;
                    end else begin
                        state_next_s = ST_HUNT;
                        idx_next_s   = 8'd0;
                    end
                end
                ST_H1: begin
                    state_next_s = ST_H2;
                    idx_next_s   = 8'd2;
                    in_frame_s   = 1'b1;
                end
                ST_H2: begin
                    state_next_s = ST_H3;
                    idx_next_s   = 8'd3;
                    in_frame_s   = 1'b1;
                end
                ST_H3: begin
                    state_next_s = ST_BODY;
                    idx_next_s   = 8'd4;
                    in_frame_s   = 1'b1;
                    hdr_accept_s = 1'b1;
                end
                ST_BODY: begin
                    if (idx_r == 8'd0) begin
                        if (byte_in == SYNC_BYTE) begin
                            state_next_s = ST_H1;
                            idx_next_s   = 8'd1;
                            in_frame_s   = 1'b1;
                            sop_s        = 1'b1;
                        end else begin
                            state_next_s = ST_HUNT;
                            idx_next_s   = 8'd0;
                            loss_s       = 1'b1;
                        end
                    end else if (idx_r == PKT_LAST) begin
                        idx_next_s = 8'd0;
                        in_frame_s = 1'b1;
                        eop_s      = 1'b1;
                    end else begin
                        idx_next_s = idx_r + 8'd1;
                        in_frame_s = 1'b1;
                    end
                end
                default: begin
                    state_next_s = ST_HUNT;
                    idx_next_s   = 8'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
            idx_next_s   = idx_r;
        end
    end

    // FSM and byte-index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_HUNT;
            idx_r   <= 8'd0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Header field capture for bytes 1 and 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tei_cap_r <= 1'b0;
            pid_hi_r  <= 5'd0;
            pid_lo_r  <= 8'd0;
        end else if (byte_valid && sync_locked && state_r == ST_H1) begin
            tei_cap_r <= byte_in[7];
            pid_hi_r  <= byte_in[4:0];
        end else if (byte_valid && sync_locked && state_r == ST_H2) begin
            pid_lo_r <= byte_in;
        end
    end

    ts_pid_table #(
        .TABLE_DEPTH (TABLE_DEPTH)
    ) u_pid_table (
        .clk         (clk),
        .rst         (rst),
        .check_en    (check_en_s),
        .pid         (hdr_pid_s),
        .cc          (byte_in[3:0]),
        .afc         (byte_in[5:4]),
        .cc_mismatch (mismatch_s),
        .full        (full_s)
    );

    // Registered outputs and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_out       <= 8'd0;
            byte_out_valid <= 1'b0;
            pkt_sop        <= 1'b0;
            pkt_eop        <= 1'b0;
            pid            <= 13'd0;
            hdr_valid      <= 1'b0;
            tei_err        <= 1'b0;
            cc_err         <= 1'b0;
            sync_loss      <= 1'b0;
            table_full     <= 1'b0;
            cc_err_count   <= 16'd0;
            pkt_count      <= 32'd0;
        end else begin
            byte_out       <= byte_in;
            byte_out_valid <= in_frame_s;
            pkt_sop        <= sop_s;
            pkt_eop        <= eop_s;
            hdr_valid      <= hdr_accept_s;
            sync_loss      <= loss_s;
            cc_err         <= hdr_accept_s && mismatch_s;
            table_full     <= full_s;
            if (hdr_accept_s) begin
                pid     <= hdr_pid_s;
                tei_err <= tei_cap_r;
            end
            if (hdr_accept_s && mismatch_s && cc_err_count != 16'hFFFF) begin
                cc_err_count <= cc_err_count + 16'd1;
            end
            if (eop_s) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ts_cc_monitor.sv
// Directed, table-driven bench for ts_cc_monitor with hand-written lock-drop and reset sequences.
module tb_ts_cc_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        sync_locked;
    logic [7:0]  byte_out;
    logic        byte_out_valid;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [12:0] pid;
    logic        hdr_valid;
    logic        tei_err;
    logic        cc_err;
    logic        sync_loss;
    logic        table_full;
    logic [15:0] cc_err_count;
    logic [31:0] pkt_count;

    int n_cmp  = 0;
    int n_fail = 0;

    ts_cc_monitor #(.TABLE_DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .sync_locked    (sync_locked),
        .byte_out       (byte_out),
        .byte_out_valid (byte_out_valid),
        .pkt_sop        (pkt_sop),
        .pkt_eop        (pkt_eop),
        .pid            (pid),
        .hdr_valid      (hdr_valid),
        .tei_err        (tei_err),
        .cc_err         (cc_err),
        .sync_loss      (sync_loss),
        .table_full     (table_full),
        .cc_err_count   (cc_err_count),
        .pkt_count      (pkt_count)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    int          mon_hdr = 0, mon_cc = 0, mon_orphan = 0, mon_loss = 0, mon_sop = 0, mon_eop = 0;
    logic [12:0] mon_pid = 13'd0;
    logic        mon_tei = 1'b0;

    always @(negedge clk) begin
        if (hdr_valid) begin
            mon_hdr <= mon_hdr + 1;
            mon_pid <= pid;
            mon_tei <= tei_err;
        end
        if (cc_err && hdr_valid) mon_cc <= mon_cc + 1;
        if (cc_err && !hdr_valid) mon_orphan <= mon_orphan + 1;
        if (sync_loss) mon_loss <= mon_loss + 1;
        if (pkt_sop) mon_sop <= mon_sop + 1;
        if (pkt_eop) mon_eop <= mon_eop + 1;
    end

    typedef struct {
        logic [7:0]  b0;
        logic [12:0] pid;
        logic        tei;
        logic [1:0]  afc;
        logic [3:0]  cc;
        int          cce;
        logic [12:0] epid;
        logic        etei;
        int          pkts;
        int          errs;
        logic        full;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input int i, input logic [7:0] b0, input logic [12:0] p,
                                            input logic tei, input logic [1:0] afc, input logic [3:0] cc);
        logic [7:0] b;
        case (i)
            0:       b = b0;
            1:       b = {tei, 2'b00, p[12:8]};
            2:       b = p[7:0];
            3:       b = {2'b00, afc, cc};
            default: b = {2'b00, i[5:0]};
        endcase
        return b;
    endfunction

    task automatic drive(input logic [7:0] b, input logic v, input logic lk);
        byte_in     = b;
        byte_valid  = v;
        sync_locked = lk;
        @(posedge clk);
        #1;
    endtask

    // Bytes [from, to) of one packet; idle cycles with 0x47 on the bus are interleaved.
    task automatic send_bytes(input logic [7:0] b0, input logic [12:0] p, input logic tei,
                              input logic [1:0] afc, input logic [3:0] cc,
                              input int from, input int to, input int drop_at);
        for (int i = from; i < to; i++) begin
            if (i == 2 || i % 50 == 25) drive(8'h47, 1'b0, 1'b1);
            drive(pkt_byte(i, b0, p, tei, afc, cc), 1'b1, i != drop_at);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(8'h47, 1'b0, 1'b1);
    endtask

    task automatic add(input logic [7:0] b0, input logic [12:0] p, input logic tei, input logic [1:0] afc,
                       input logic [3:0] cc, input int cce, input logic [12:0] epid, input logic etei,
                       input int pkts, input int errs, input logic full);
        vec_t v;
        v = '{b0, p, tei, afc, cc, cce, epid, etei, pkts, errs, full};
        vecs.push_back(v);
    endtask

    int s_hdr, s_cc, s_loss, s_sop, s_eop;

    task automatic snap();
        s_hdr  = mon_hdr;
        s_cc   = mon_cc;
        s_loss = mon_loss;
        s_sop  = mon_sop;
        s_eop  = mon_eop;
    endtask

    initial begin
        rst         = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        sync_locked = 1'b0;
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 0, {19'd0, byte_out, byte_out_valid, pkt_sop, pkt_eop, hdr_valid,
                                   tei_err, cc_err, sync_loss, table_full}, 32'd0);
        check("reset_pid", 0, {19'd0, pid}, 32'd0);
        check("reset_ccerr_count", 0, {16'd0, cc_err_count}, 32'd0);
        check("reset_pkt_count", 0, pkt_count, 32'd0);
        rst = 1'b0;

        drive(8'h5A, 1'b1, 1'b0);
        check("byte_out_delay", 0, {24'd0, byte_out}, 32'h5A);
        check("byte_out_valid_unlocked", 0, {31'd0, byte_out_valid}, 32'd0);
        idle(2);

        //   b0     pid      tei   afc    cc  cce  epid    etei pkts errs full
        add(8'h47, 13'h100,  1'b0, 2'b01, 4'd0,  0, 13'h100, 1'b0,  1, 0, 1'b0);
        add(8'h47, 13'h100,  1'b0, 2'b01, 4'd1,  0, 13'h100, 1'b0,  2, 0, 1'b0);
        add(8'h47, 13'h100,  1'b0, 2'b01, 4'd2,  0, 13'h100, 1'b0,  3, 0, 1'b0);
        add(8'h47, 13'h101,  1'b0, 2'b01, 4'd0,  0, 13'h101, 1'b0,  4, 0, 1'b0);
        add(8'h47, 13'h101,  1'b0, 2'b01, 4'd1,  0, 13'h101, 1'b0,  5, 0, 1'b0);
        add(8'h47, 13'h101,  1'b0, 2'b01, 4'd1,  0, 13'h101, 1'b0,  6, 0, 1'b0);
        add(8'h47, 13'h101,  1'b0, 2'b01, 4'd1,  1, 13'h101, 1'b0,  7, 1, 1'b0);
        add(8'h47, 13'h102,  1'b0, 2'b01, 4'd5,  0, 13'h102, 1'b0,  8, 1, 1'b0);
        add(8'h47, 13'h102,  1'b0, 2'b10, 4'd5,  0, 13'h102, 1'b0,  9, 1, 1'b0);
        add(8'h47, 13'h102,  1'b0, 2'b01, 4'd9,  1, 13'h102, 1'b0, 10, 2, 1'b0);
        add(8'h47, 13'h1FFF, 1'b0, 2'b01, 4'd7,  0, 13'h1FFF, 1'b0, 11, 2, 1'b0);
        add(8'h47, 13'h1FFF, 1'b0, 2'b01, 4'd3,  0, 13'h1FFF, 1'b0, 12, 2, 1'b0);
        add(8'h47, 13'h100,  1'b1, 2'b01, 4'd15, 0, 13'h100, 1'b1, 13, 2, 1'b0);
        add(8'h47, 13'h100,  1'b0, 2'b01, 4'd3,  0, 13'h100, 1'b0, 14, 2, 1'b0);
        add(8'h00, 13'h100,  1'b0, 2'b01, 4'd0,  0, 13'h100, 1'b0, 14, 2, 1'b0);
        add(8'h47, 13'h100,  1'b0, 2'b01, 4'd4,  0, 13'h100, 1'b0, 15, 2, 1'b0);
        add(8'h47, 13'h103,  1'b0, 2'b11, 4'd0,  0, 13'h103, 1'b0, 16, 2, 1'b0);
        add(8'h47, 13'h104,  1'b0, 2'b01, 4'd0,  0, 13'h104, 1'b0, 17, 2, 1'b0);
        add(8'h47, 13'h105,  1'b0, 2'b01, 4'd0,  0, 13'h105, 1'b0, 18, 2, 1'b0);
        add(8'h47, 13'h106,  1'b0, 2'b01, 4'd0,  0, 13'h106, 1'b0, 19, 2, 1'b0);
        add(8'h47, 13'h107,  1'b0, 2'b01, 4'd0,  0, 13'h107, 1'b0, 20, 2, 1'b1);
        add(8'h47, 13'h108,  1'b0, 2'b01, 4'd0,  0, 13'h108, 1'b0, 21, 2, 1'b1);
        add(8'h47, 13'h108,  1'b0, 2'b01, 4'd9,  0, 13'h108, 1'b0, 22, 2, 1'b1);
        add(8'h47, 13'h100,  1'b0, 2'b01, 4'd7,  1, 13'h100, 1'b0, 23, 3, 1'b1);
        add(8'h47, 13'h101,  1'b0, 2'b00, 4'd5,  1, 13'h101, 1'b0, 24, 4, 1'b1);
        add(8'h47, 13'h101,  1'b0, 2'b01, 4'd6,  0, 13'h101, 1'b0, 25, 4, 1'b1);

        for (int k = 0; k < vecs.size(); k++) begin
            int ok;
            ok = (vecs[k].b0 == 8'h47) ? 1 : 0;
            snap();
            send_bytes(vecs[k].b0, vecs[k].pid, vecs[k].tei, vecs[k].afc, vecs[k].cc, 0, 188, -1);
            idle(2);
            check("hdr_valid_pulses", k, mon_hdr - s_hdr, ok);
            check("pkt_sop_pulses", k, mon_sop - s_sop, ok);
            check("pkt_eop_pulses", k, mon_eop - s_eop, ok);
            check("sync_loss_pulses", k, mon_loss - s_loss, 1 - ok);
            check("cc_err_pulses", k, mon_cc - s_cc, vecs[k].cce);
            check("pid_held", k, {19'd0, pid}, {19'd0, vecs[k].epid});
            if (ok == 1) begin
                check("pid_at_hdr", k, {19'd0, mon_pid}, {19'd0, vecs[k].epid});
                check("tei_at_hdr", k, {31'd0, mon_tei}, {31'd0, vecs[k].etei});
            end
            check("pkt_count", k, pkt_count, vecs[k].pkts);
            check("cc_err_count", k, {16'd0, cc_err_count}, vecs[k].errs);
            check("table_full", k, {31'd0, table_full}, {31'd0, vecs[k].full});
        end

        // Reset in the middle of a packet (after byte index 99 was accepted).
        snap();
        send_bytes(8'h47, 13'h101, 1'b0, 2'b01, 4'd7, 0, 100, -1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", 100, {19'd0, byte_out, byte_out_valid, pkt_sop, pkt_eop, hdr_valid,
                                      tei_err, cc_err, sync_loss, table_full}, 32'd0);
        check("midrst_pid", 100, {19'd0, pid}, 32'd0);
        check("midrst_ccerr_count", 100, {16'd0, cc_err_count}, 32'd0);
        check("midrst_pkt_count", 100, pkt_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_bytes(8'h47, 13'h101, 1'b0, 2'b01, 4'd7, 100, 188, -1);
        idle(2);
        check("midrst_no_eop", 100, mon_eop - s_eop, 0);
        check("midrst_pkt_count_after", 100, pkt_count, 32'd0);

        // Table was cleared: PID 0x101 CC 9 allocates fresh, no error.
        snap();
        send_bytes(8'h47, 13'h101, 1'b0, 2'b01, 4'd9, 0, 188, -1);
        idle(2);
        check("postrst_hdr", 200, mon_hdr - s_hdr, 1);
        check("postrst_cc_err", 200, mon_cc - s_cc, 0);
        check("postrst_pkt_count", 200, pkt_count, 32'd1);
        check("postrst_table_full", 200, {31'd0, table_full}, 32'd0);

        // Lock drops at byte 60: packet aborted without pkt_eop.
        snap();
        send_bytes(8'h47, 13'h200, 1'b0, 2'b01, 4'd0, 0, 188, 60);
        idle(2);
        check("lockdrop_no_eop", 300, mon_eop - s_eop, 0);
        check("lockdrop_pkt_count", 300, pkt_count, 32'd1);

        // Re-acquisition after the abort, continuing PID 0x101.
        snap();
        send_bytes(8'h47, 13'h101, 1'b0, 2'b01, 4'd10, 0, 188, -1);
        idle(2);
        check("relock_hdr", 400, mon_hdr - s_hdr, 1);
        check("relock_cc_err", 400, mon_cc - s_cc, 0);
        check("relock_pid", 400, {19'd0, pid}, 32'h101);
        check("relock_pkt_count", 400, pkt_count, 32'd2);

        check("cc_err_without_hdr", 500, mon_orphan, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
